// File: rtl/jesd204b_tpl_pkg.sv
// ============================================================================
// Module   : jesd204b_tpl_pkg
// Brief    : Derived link geometry helpers and FSM state codes for the TPL RX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package jesd204b_tpl_pkg;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } tpl_state_e;

    // Converter count rounded up so every lane carries the same number of converters.
    function automatic int calc_mp(input int converters, input int lanes);
        return ((converters + lanes - 1) / lanes) * lanes;
    endfunction

    function automatic int calc_cpl(input int mp, input int lanes);
        return mp / lanes;
    endfunction

    function automatic int calc_fb(input int samples, input int sample_size, input int cpl);
        return samples * sample_size * cpl;
    endfunction

    function automatic int calc_frame_beats(input int fb, input int bw);
        return fb / bw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jesd204b_tpl_word_split.sv
// ============================================================================
// Module   : jesd204b_tpl_word_split
// Brief    : Splits one sample word into data, control and a tail-non-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jesd204b_tpl_word_split
    import jesd204b_tpl_pkg::*;
#(
    parameter int SAMPLE_SIZE = 16,
    parameter int RESOLUTION  = 11,
    parameter int CONTROL     = 2
) (
    input  logic [SAMPLE_SIZE-1:0] word_i,
    output logic [RESOLUTION-1:0]  data_o,
    output logic [CONTROL-1:0]     ctrl_o,
    output logic                   tail_nz_o
);

    localparam int TAIL = SAMPLE_SIZE - RESOLUTION - CONTROL;

    assign data_o = word_i[SAMPLE_SIZE-1 -: RESOLUTION];
    assign ctrl_o = word_i[SAMPLE_SIZE-RESOLUTION-1 -: CONTROL];

    generate
        if (TAIL > 0) begin : g_tail
            assign tail_nz_o = |word_i[TAIL-1:0];
        end else begin : g_no_tail
            assign tail_nz_o = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/jesd204b_tpl_rx_deframer.sv
// ============================================================================
// Module   : jesd204b_tpl_rx_deframer
// Brief    : Multi-beat JESD204B transport-layer RX: frame collection, deframing,
//            sof alignment and tail-bit checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jesd204b_tpl_rx_deframer
    import jesd204b_tpl_pkg::*;
#(
    parameter int LANES           = 4,
    parameter int CONVERTERS      = 8,
    parameter int RESOLUTION      = 11,
    parameter int CONTROL         = 2,
    parameter int SAMPLE_SIZE     = 16,
    parameter int SAMPLES         = 1,
    parameter int OCTETS_PER_BEAT = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   rx_valid,
    input  logic                                   rx_sof,
    input  logic [LANES*8*OCTETS_PER_BEAT-1:0]     rx_datain,
    output logic [SAMPLES*CONVERTERS*RESOLUTION-1:0] rx_dataout,
    output logic [SAMPLES*CONVERTERS*CONTROL-1:0]    rx_ctrlout,
    output logic                                   rx_out_valid,
    output logic                                   sof_err,
    output logic                                   tail_err,
    input  logic                                   err_clr
);

    localparam int BW          = 8 * OCTETS_PER_BEAT;
    localparam int MP          = calc_mp(CONVERTERS, LANES);
    localparam int CPL         = calc_cpl(MP, LANES);
    localparam int FB          = calc_fb(SAMPLES, SAMPLE_SIZE, CPL);
    localparam int FRAME_BEATS = calc_frame_beats(FB, BW);
    localparam int CW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int NW          = CONVERTERS * SAMPLES;
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);

    generate
        if (FB % BW != 0) begin : g_err_fb
            $error("frame bits per lane must be a multiple of the beat width");
        end
        if (RESOLUTION + CONTROL > SAMPLE_SIZE) begin : g_err_ss
            $error("RESOLUTION + CONTROL exceeds SAMPLE_SIZE");
        end
    endgenerate

    tpl_state_e                 state_q, state_d;
    logic [CW-1:0]              beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]              w_beat_idx;
    logic                       w_accept;
    logic                       w_complete;
    logic                       w_sof_err_set;

    logic [LANES-1:0][FB-1:0]   w_frame;
    logic [NW*RESOLUTION-1:0]   w_data;
    logic [NW*CONTROL-1:0]      w_ctrl;
    logic [NW-1:0]              w_tail_nz;

    logic [NW*RESOLUTION-1:0]   dataout_q;
    logic [NW*CONTROL-1:0]      ctrlout_q;
    logic                       out_valid_q;
    logic                       sof_err_q;
    logic                       tail_err_q;

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        w_beat_idx    = beat_cnt_q;
        w_accept      = 1'b0;
        w_complete    = 1'b0;
        w_sof_err_set = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (rx_valid && rx_sof) begin
                    w_accept   = 1'b1;
                    w_beat_idx = '0;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    // A misplaced sof restarts the frame on this beat.
                    if (rx_sof && beat_cnt_q != '0) begin
                        w_sof_err_set = 1'b1;
                        w_accept      = 1'b1;
                        w_beat_idx    = '0;
                    end else if (!rx_sof && beat_cnt_q == '0) begin
                        w_sof_err_set = 1'b1;
                        state_d       = ST_HUNT;
                    end else begin
                        w_accept = 1'b1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
        if (w_accept) begin
            state_d    = ST_COLLECT;
            w_complete = (w_beat_idx == LAST_BEAT);
            beat_cnt_d = w_complete ? '0 : w_beat_idx + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Earlier beats are held in a history register; the current beat forms the frame LSBs.
    generate
        if (FRAME_BEATS > 1) begin : g_multi
            logic [LANES-1:0][FB-BW-1:0] hist_q;
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                assign w_frame[l] = {hist_q[l], rx_datain[l*BW +: BW]};
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_q <= '0;
                end else if (w_accept) begin
                    for (int l = 0; l < LANES; l++) begin
                        hist_q[l] <= w_frame[l][FB-BW-1:0];
                    end
                end
            end
        end else begin : g_single
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                assign w_frame[l] = rx_datain[l*BW +: BW];
            end
        end
    endgenerate

    generate
        for (genvar c = 0; c < CONVERTERS; c++) begin : g_conv
            for (genvar s = 0; s < SAMPLES; s++) begin : g_smp
                localparam int LANE = c / CPL;
                localparam int WORD = (c % CPL) * SAMPLES + s;
                localparam int IDX  = c * SAMPLES + s;
                jesd204b_tpl_word_split #(
                    .SAMPLE_SIZE (SAMPLE_SIZE),
                    .RESOLUTION  (RESOLUTION),
                    .CONTROL     (CONTROL)
                ) u_split (
                    .word_i    (w_frame[LANE][FB-1-WORD*SAMPLE_SIZE -: SAMPLE_SIZE]),
                    .data_o    (w_data[IDX*RESOLUTION +: RESOLUTION]),
                    .ctrl_o    (w_ctrl[IDX*CONTROL +: CONTROL]),
                    .tail_nz_o (w_tail_nz[IDX])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_q   <= '0;
            ctrlout_q   <= '0;
            out_valid_q <= 1'b0;
            sof_err_q   <= 1'b0;
            tail_err_q  <= 1'b0;
        end else begin
            out_valid_q <= w_complete;
            if (w_complete) begin
                dataout_q <= w_data;
                ctrlout_q <= w_ctrl;
            end
            sof_err_q  <= w_sof_err_set | (sof_err_q & ~err_clr);
            tail_err_q <= (w_complete & (|w_tail_nz)) | (tail_err_q & ~err_clr);
        end
    end

    assign rx_dataout   = dataout_q;
    assign rx_ctrlout   = ctrlout_q;
    assign rx_out_valid = out_valid_q;
    assign sof_err      = sof_err_q;
    assign tail_err     = tail_err_q;

endmodule

`default_nettype wire

// File: tb/tb_jesd204b_tpl_rx_deframer.sv
// ============================================================================
// Module   : tb_jesd204b_tpl_rx_deframer
// Brief    : Directed scoreboard bench for the TPL RX deframer (default geometry).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jesd204b_tpl_rx_deframer;

    logic         clk;
    logic         rst_n;
    logic         rx_valid;
    logic         rx_sof;
    logic [63:0]  rx_datain;
    logic [87:0]  rx_dataout;
    logic [15:0]  rx_ctrlout;
    logic         rx_out_valid;
    logic         sof_err;
    logic         tail_err;
    logic         err_clr;

    typedef struct {
        logic [87:0] data;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_assert = 0;
    int   n_fail   = 0;

    jesd204b_tpl_rx_deframer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_datain    (rx_datain),
        .rx_dataout   (rx_dataout),
        .rx_ctrlout   (rx_ctrlout),
        .rx_out_valid (rx_out_valid),
        .sof_err      (sof_err),
        .tail_err     (tail_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference deframing: lane l frame = {beat0, beat1}; conv c -> lane c/2, word c%2.
    function automatic exp_t model(input logic [63:0] b0, input logic [63:0] b1);
        exp_t        e;
        logic [31:0] fr;
        logic [15:0] wd;
        for (int c = 0; c < 8; c++) begin
            fr = {b0[(c/2)*16 +: 16], b1[(c/2)*16 +: 16]};
            wd = (c % 2 == 0) ? fr[31:16] : fr[15:0];
            e.data[c*11 +: 11] = wd[15:5];
            e.ctrl[c*2 +: 2]   = wd[4:3];
        end
        return e;
    endfunction

    function automatic logic [63:0] mk_beat(input logic [15:0] l0);
        logic [63:0] b;
        b[15:0] = l0;
        for (int l = 1; l < 4; l++) begin
            b[l*16 +: 16] = 16'($urandom()) & 16'hFFF8;
        end
        return b;
    endfunction

    task automatic push(input logic [63:0] b0, input logic [63:0] b1);
        sb.push_back(model(b0, b1));
    endtask

    task automatic cyc(input logic v, input logic s, input logic [63:0] d, input logic expv);
        exp_t e;
        rx_valid  = v;
        rx_sof    = s;
        rx_datain = d;
        @(posedge clk);
        #1;
        chk("out_valid", rx_out_valid, expv);
        if (expv && sb.size() > 0) begin
            e = sb.pop_front();
            chk("dataout", rx_dataout, e.data);
            chk("ctrlout", rx_ctrlout, e.ctrl);
            last_exp = e;
        end
    endtask

    initial begin
        logic [63:0] b0, b1, bx, ba;

        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        rx_datain = '0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataout", rx_dataout, 0);
        chk("rst_ctrlout", rx_ctrlout, 0);
        chk("rst_out_valid", rx_out_valid, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_tail_err", tail_err, 0);
        rst_n = 1'b1;

        // Reference frame with known conv0/conv1 values.
        b0 = mk_beat(16'hcf60);
        b1 = mk_beat(16'hd760);
        push(b0, b1);
        cyc(1'b1, 1'b1, b0, 1'b0);
        cyc(1'b1, 1'b0, b1, 1'b1);
        chk("conv0_data", rx_dataout[10:0], 11'h67B);
        chk("conv1_data", rx_dataout[21:11], 11'h6BB);
        chk("conv01_ctrl", rx_ctrlout[3:0], 4'b0000);
        chk("tail_err_clean", tail_err, 0);
        chk("sof_err_clean", sof_err, 0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("hold_data", rx_dataout, last_exp.data);

        // Same frame with bubbles between beats.
        push(b0, b1);
        cyc(1'b1, 1'b1, b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, mk_beat(16'h1234), 1'b0);
        cyc(1'b1, 1'b0, b1, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);

        // Back-to-back random frames.
        for (int i = 0; i < 4; i++) begin
            b0 = mk_beat(16'($urandom()) & 16'hFFF8);
            b1 = mk_beat(16'($urandom()) & 16'hFFF8);
            push(b0, b1);
            cyc(1'b1, 1'b1, b0, 1'b0);
            cyc(1'b1, 1'b0, b1, 1'b1);
        end
        chk("no_err_random", {sof_err, tail_err}, 2'b00);

        // Non-zero tail on lane0 word0.
        b0 = mk_beat(16'hcf64);
        b1 = mk_beat(16'hd760);
        push(b0, b1);
        cyc(1'b1, 1'b1, b0, 1'b0);
        cyc(1'b1, 1'b0, b1, 1'b1);
        chk("tail_err_set", tail_err, 1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("tail_err_sticky", tail_err, 1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        err_clr = 1'b0;
        chk("tail_err_cleared", tail_err, 0);

        // sof on beat1 restarts the frame.
        b0 = mk_beat(16'h0aa8);
        bx = mk_beat(16'h5550);
        b1 = mk_beat(16'h3338);
        cyc(1'b1, 1'b1, b0, 1'b0);
        push(bx, b1);
        cyc(1'b1, 1'b1, bx, 1'b0);
        chk("sof_err_misplaced", sof_err, 1);
        cyc(1'b1, 1'b0, b1, 1'b1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        err_clr = 1'b0;
        chk("sof_err_cleared", sof_err, 0);

        // Missing sof on expected beat 0: back to HUNT, non-sof beats ignored.
        ba = mk_beat(16'h7778);
        cyc(1'b1, 1'b0, ba, 1'b0);
        chk("sof_err_missing", sof_err, 1);
        cyc(1'b1, 1'b0, mk_beat(16'h1110), 1'b0);
        cyc(1'b1, 1'b0, mk_beat(16'h2220), 1'b0);
        b0 = mk_beat(16'h8888);
        b1 = mk_beat(16'h9990);
        push(b0, b1);
        cyc(1'b1, 1'b1, b0, 1'b0);
        cyc(1'b1, 1'b0, b1, 1'b1);
        chk("sof_err_still_sticky", sof_err, 1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        err_clr = 1'b0;

        // New error in the same cycle as err_clr: error wins.
        b0 = mk_beat(16'h4440);
        bx = mk_beat(16'habc0);
        b1 = mk_beat(16'hdef0);
        cyc(1'b1, 1'b1, b0, 1'b0);
        err_clr = 1'b1;
        push(bx, b1);
        cyc(1'b1, 1'b1, bx, 1'b0);
        chk("err_wins_over_clr", sof_err, 1);
        cyc(1'b1, 1'b0, b1, 1'b1);
        chk("clr_after_err", sof_err, 0);
        err_clr = 1'b0;

        // Reset mid-frame.
        b0 = mk_beat(16'hfff8);
        cyc(1'b1, 1'b1, b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_dataout", rx_dataout, 0);
        chk("midrst_ctrlout", rx_ctrlout, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = mk_beat(16'hcf60);
        b1 = mk_beat(16'hd760);
        push(b0, b1);
        cyc(1'b1, 1'b0, b1, 1'b0);
        cyc(1'b1, 1'b1, b0, 1'b0);
        cyc(1'b1, 1'b0, b1, 1'b1);
        chk("postrst_errs", {sof_err, tail_err}, 2'b00);
        cyc(1'b0, 1'b0, '0, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
